// File: rtl/fpr_file.sv
// rtl/fpr_file.sv - parametrised FP register file with busy scoreboard
// Optional feature: define FPR_BYPASS_EN for same-cycle write-to-read forwarding.
module fpr_file #(
  parameter int DW  = 64,
  parameter int AW  = 4,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wr,
  input  logic [AW-1:0]     fd,
  input  logic [DW-1:0]     din,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_vld,
  input  logic [AW-1:0]     iss_fd,
  output logic              iss_rdy,
  input  logic              flush
);

  localparam int NREG = 1 << AW;
  localparam int HW   = DW / 2;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic            wr_en;

  assign wr_en = (wr != 2'b00);

  // A register being written back this cycle may be re-reserved at once.
  assign iss_rdy = ~busy[iss_fd] | (wr_en && (fd == iss_fd));

  // Register array: halves are written independently, reset clears all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      if (wr[1]) regs[fd][DW-1:HW] <= din[DW-1:HW];
      if (wr[0]) regs[fd][HW-1:0]  <= din[HW-1:0];
    end
  end

  // Scoreboard: flush beats everything, issue set beats writeback release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (iss_vld && iss_rdy && (iss_fd == AW'(i))) busy[i] <= 1'b1;
        else if (wr_en && (fd == AW'(i)))             busy[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] a;
    logic [DW-1:0] q;
    logic          b;

    assign a = raddr[k*AW +: AW];

    // Combinational read of one port, optionally merging in the in-flight write.
    always_comb begin
      q = regs[a];
      b = busy[a];
`ifdef FPR_BYPASS_EN
      if (wr_en && (fd == a)) begin
        if (wr[1]) q[DW-1:HW] = din[DW-1:HW];
        if (wr[0]) q[HW-1:0]  = din[HW-1:0];
        b = 1'b0;
      end
`endif
    end

    assign rdata[k*DW +: DW] = q;
    assign rbusy[k]          = b;
  end

endmodule

// File: tb/tb_fpr_file.sv
// tb/tb_fpr_file.sv - randomized self-checking bench for fpr_file
module tb_fpr_file;
  localparam int DW = 64, AW = 4, NRD = 2, NREG = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        wr;
  logic [AW-1:0]     fd;
  logic [DW-1:0]     din;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              iss_vld;
  logic [AW-1:0]     iss_fd;
  logic              iss_rdy;
  logic              flush;

  logic [1:0]  s_wr;
  logic [4:0]  s_fd;
  logic [31:0] s_din;
  logic [14:0] s_raddr;
  logic [95:0] s_rdata;
  logic [2:0]  s_rbusy;
  logic        s_iss_vld;
  logic [4:0]  s_iss_fd;
  logic        s_iss_rdy;
  logic        s_flush;

  fpr_file #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .fd(fd), .din(din), .raddr(raddr),
    .rdata(rdata), .rbusy(rbusy), .iss_vld(iss_vld), .iss_fd(iss_fd),
    .iss_rdy(iss_rdy), .flush(flush)
  );

  fpr_file #(.DW(32), .AW(5), .NRD(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr(s_wr), .fd(s_fd), .din(s_din), .raddr(s_raddr),
    .rdata(s_rdata), .rbusy(s_rbusy), .iss_vld(s_iss_vld), .iss_fd(s_iss_fd),
    .iss_rdy(s_iss_rdy), .flush(s_flush)
  );

  logic [63:0] mem_m  [NREG];
  bit          busy_m [NREG];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      mem_m[i]  = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  function automatic logic [63:0] model_rd(input int a);
    logic [63:0] v;
    v = mem_m[a];
`ifdef FPR_BYPASS_EN
    if (wr != 2'b00 && int'(fd) == a) begin
      if (wr[1]) v[63:32] = din[63:32];
      if (wr[0]) v[31:0]  = din[31:0];
    end
`endif
    return v;
  endfunction

  function automatic bit model_rbusy(input int a);
    bit b;
    b = busy_m[a];
`ifdef FPR_BYPASS_EN
    if (wr != 2'b00 && int'(fd) == a) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic bit model_rdy();
    return !busy_m[iss_fd] || (wr != 2'b00 && fd == iss_fd);
  endfunction

  task automatic drive(input logic [1:0] w, input int f, input logic [63:0] d,
                       input int r0, input int r1, input bit iv, input int ifd, input bit fl);
    wr = w; fd = AW'(f); din = d;
    raddr = {AW'(r1), AW'(r0)};
    iss_vld = iv; iss_fd = AW'(ifd); flush = fl;
  endtask

  // Check all outputs at the falling edge, then advance the model over the rising edge.
  task automatic step();
    bit rdy;
    @(negedge clk);
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rdata%0d", k), rdata[k*DW +: DW], model_rd(int'(raddr[k*AW +: AW])));
      chk($sformatf("rbusy%0d", k), 64'(rbusy[k]), 64'(model_rbusy(int'(raddr[k*AW +: AW]))));
    end
    rdy = model_rdy();
    chk("iss_rdy", 64'(iss_rdy), 64'(rdy));
    if (wr[1]) mem_m[fd][63:32] = din[63:32];
    if (wr[0]) mem_m[fd][31:0]  = din[31:0];
    if (flush) begin
      for (int i = 0; i < NREG; i++) busy_m[i] = 1'b0;
    end else begin
      if (wr != 2'b00) busy_m[fd] = 1'b0;
      if (iss_vld && rdy) busy_m[iss_fd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic peek0(input string tag, input logic [63:0] exp);
    #2;
    chk(tag, rdata[63:0], exp);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 0, '0, 0, 0, 1'b0, 0, 1'b0);
    s_wr = 2'b00; s_fd = '0; s_din = '0; s_raddr = '0;
    s_iss_vld = 1'b0; s_iss_fd = '0; s_flush = 1'b0;
    model_reset();
    #3;
    chk("reset_rdata", rdata[63:0], 64'h0);
    chk("reset_iss_rdy", 64'(iss_rdy), 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NREG / 2; i++) begin
      drive(2'b00, 0, '0, 2*i, 2*i+1, 1'b0, i, 1'b0);
      #2;
      chk("reset_read", rdata, 128'h0);
      chk("reset_rbusy", 64'(rbusy), 64'h0);
      step();
    end

    drive(2'b11, 3, 64'h1122334455667788, 3, 0, 1'b0, 0, 1'b0); step();
    drive(2'b10, 3, 64'hAAAAAAAA00000000, 3, 0, 1'b0, 0, 1'b0); step();
    drive(2'b00, 3, '0, 3, 3, 1'b0, 0, 1'b0);
    peek0("half_upper", 64'hAAAAAAAA55667788); step();
    drive(2'b01, 3, 64'h00000000BBBBBBBB, 3, 0, 1'b0, 0, 1'b0); step();
    drive(2'b00, 3, '0, 3, 3, 1'b0, 0, 1'b0);
    peek0("half_lower", 64'hAAAAAAAABBBBBBBB); step();

    drive(2'b00, 0, '0, 5, 0, 1'b1, 5, 1'b0); step();
    drive(2'b00, 0, '0, 5, 0, 1'b0, 5, 1'b0);
    #2;
    chk("busy5_rdy", 64'(iss_rdy), 64'h0);
    chk("busy5_rbusy", 64'(rbusy[0]), 64'h1);
    step();
    drive(2'b11, 5, 64'h5555, 5, 0, 1'b1, 5, 1'b0);
    #2; chk("wb_iss_rdy", 64'(iss_rdy), 64'h1);
    step();
    drive(2'b00, 0, '0, 5, 0, 1'b0, 5, 1'b0);
    #2; chk("set_wins", 64'(rbusy[0]), 64'h1);
    step();
    drive(2'b01, 5, 64'h7777, 0, 0, 1'b0, 0, 1'b0); step();
    drive(2'b00, 0, '0, 5, 0, 1'b0, 5, 1'b0);
    #2; chk("release5", 64'(rbusy[0]), 64'h0);
    step();

    drive(2'b00, 0, '0, 0, 0, 1'b1, 1, 1'b0); step();
    drive(2'b00, 0, '0, 0, 0, 1'b1, 2, 1'b0); step();
    drive(2'b00, 0, '0, 1, 2, 1'b1, 7, 1'b0); step();
    drive(2'b00, 0, '0, 7, 1, 1'b1, 3, 1'b1);
    #2; chk("pre_flush", 64'(rbusy), 64'h3);
    step();
    drive(2'b00, 0, '0, 7, 3, 1'b0, 2, 1'b0);
    #2; chk("post_flush", 64'(rbusy), 64'h0);
    step();

    drive(2'b11, 4, 64'hDEADBEEFCAFEF00D, 4, 0, 1'b0, 0, 1'b0);
`ifdef FPR_BYPASS_EN
    peek0("bypass_same", 64'hDEADBEEFCAFEF00D);
`else
    peek0("bypass_same", 64'h0);
`endif
    step();
    drive(2'b00, 0, '0, 4, 0, 1'b0, 0, 1'b0);
    peek0("bypass_next", 64'hDEADBEEFCAFEF00D); step();

    drive(2'b11, 9, 64'h0909090909090909, 0, 0, 1'b1, 9, 1'b0); step();
    drive(2'b00, 0, '0, 9, 9, 1'b0, 9, 1'b0);
    peek0("reg9_written", 64'h0909090909090909);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_rdata", rdata[63:0], 64'h0);
    chk("reset_mid_rdy", 64'(iss_rdy), 64'h1);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    s_wr = 2'b11; s_fd = 5'd0;  s_din = 32'h01234567; @(posedge clk); #1;
    s_fd = 5'd31; s_din = 32'h89ABCDEF;               @(posedge clk); #1;
    s_fd = 5'd30; s_din = 32'h5A5A5A5A;               @(posedge clk); #1;
    s_wr = 2'b00; s_raddr = {5'd31, 5'd31, 5'd0};
    #2;
    chk("s_port0", 64'(s_rdata[31:0]),  64'h01234567);
    chk("s_port1", 64'(s_rdata[63:32]), 64'h89ABCDEF);
    chk("s_port2", 64'(s_rdata[95:64]), 64'h89ABCDEF);
    s_iss_vld = 1'b1; s_iss_fd = 5'd31;
    @(posedge clk); #1;
    s_iss_vld = 1'b0; s_raddr = {5'd31, 5'd30, 5'd31};
    #2;
    chk("s_rbusy", 64'(s_rbusy), 64'h5);
    chk("s_port1b", 64'(s_rdata[63:32]), 64'h5A5A5A5A);
    chk("s_rdy", 64'(s_iss_rdy), 64'h0);

    for (int n = 0; n < 1500; n++) begin
      drive(2'($urandom_range(0, 3)), int'($urandom_range(0, NREG-1)),
            {$urandom, $urandom}, int'($urandom_range(0, NREG-1)),
            int'($urandom_range(0, NREG-1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, NREG-1)), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) wr = 2'b00;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
